// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word reads to
// instruction memory and buffers returned words with their PC for decode.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_reg, rsp_pc_reg;
    logic [CW-1:0] occ_reg, outstanding_reg, drop_cnt_reg;
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0]   inst_out_reg, inst_pc_reg;
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];

    logic          req_fire, push, pop;
    logic [CW-1:0] occ_after_pop, occ_next, outstanding_next, drop_cnt_next;
    logic [PW-1:0] rd_ptr_next;
    logic [31:0]   head_data_next, head_pc_next;
    logic [31:0]   redirect_aligned;
    logic          unused_redirect_bits;

    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Credits count buffered plus in-flight words, so the FIFO can never overflow.
    assign imem_req_valid = !rst && !redirect_valid &&
                            ((occ_reg + outstanding_reg) < DEPTH_C);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (occ_reg != '0);
    assign inst_out   = inst_out_reg;
    assign inst_pc    = inst_pc_reg;
    assign pop        = inst_valid && inst_ready;
    assign push       = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

    always_comb begin
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        occ_after_pop    = occ_reg - CW'(pop);
        rd_ptr_next      = rd_ptr_reg + PW'(pop);
        if (redirect_valid) begin
            occ_next      = '0;
            drop_cnt_next = outstanding_reg - CW'(imem_rsp_valid);
        end else begin
            occ_next      = occ_after_pop + CW'(push);
            drop_cnt_next = drop_cnt_reg;
            if (imem_rsp_valid && drop_cnt_reg != '0)
                drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    // Next head: the word being pushed if the buffer drains to empty, else the stored entry.
    always_comb begin
        head_data_next = data_mem[rd_ptr_next];
        head_pc_next   = pc_mem[rd_ptr_next];
        if (occ_after_pop == '0) begin
            head_data_next = imem_rsp_data;
            head_pc_next   = rsp_pc_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            occ_reg         <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            inst_out_reg    <= '0;
            inst_pc_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            occ_reg         <= occ_next;
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_aligned;
                rsp_pc_reg   <= redirect_aligned;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                if (push) begin
                    rsp_pc_reg <= rsp_pc_reg + 32'd4;
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                rd_ptr_reg <= rd_ptr_next;
            end
            if (occ_next != '0) begin
                inst_out_reg <= head_data_next;
                inst_pc_reg  <= head_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ_reg == DEPTH_C));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed tables, corner sequences and
// randomized traffic against a queue-based reference model with an in-order memory.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_out, inst_pc;

    fetch_prefetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] pc; bit drop; } fl_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { bit rr; bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc; } vec_t;

    ent_t        m_fifo[$];
    fl_t         m_infl[$];
    pend_t       pend[$];
    logic [31:0] popped[$];
    logic [31:0] m_fetch_pc, m_head_data, m_head_pc;
    int          cyc = 0, tests = 0, fails = 0, lat_lo = 1, lat_hi = 1, dut_out = 0;
    bit          verbose = 1'b1;
    bit          obs_rv, obs_iv;
    logic [31:0] obs_addr, obs_pc, obs_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_inst_out", inst_out, 0);
            chk("rst_inst_pc", inst_pc, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        m_fifo.delete(); m_infl.delete(); pend.delete();
        m_fetch_pc = RST_PC; m_head_data = '0; m_head_pc = '0;
        dut_out = 0;
        cyc++;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic tick(input bit rr, input bit ir, input bit redir, input logic [31:0] rpc);
        bit          rsp, exp_rv, exp_iv, fire, pop;
        logic [31:0] exp_out, exp_pc;
        fl_t         f;
        ent_t        e;
        pend_t       p;
        int          due;
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_req_ready = rr; inst_ready = ir; redirect_valid = redir; redirect_pc = rpc;
        imem_rsp_valid = rsp;
        if (rsp) imem_rsp_data = mem_word(pend[0].addr);
        else     imem_rsp_data = $urandom();
        #1;
        exp_rv = !redir && ((m_fifo.size() + m_infl.size()) < DEPTH);
        exp_iv = (m_fifo.size() != 0);
        if (exp_iv) begin exp_out = m_fifo[0].data; exp_pc = m_fifo[0].pc; end
        else        begin exp_out = m_head_data;    exp_pc = m_head_pc;    end
        obs_rv = imem_req_valid; obs_addr = imem_req_addr;
        obs_iv = inst_valid; obs_pc = inst_pc; obs_out = inst_out;
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("inst_valid", inst_valid, exp_iv);
        chk("inst_out", inst_out, exp_out);
        chk("inst_pc", inst_pc, exp_pc);
        if (inst_valid && ir) popped.push_back(inst_pc);
        if (imem_req_valid && rr) dut_out++;
        if (rsp) dut_out--;
        chk("outstanding_bound", dut_out <= DEPTH, 1);

        fire = exp_rv && rr;
        pop  = exp_iv && ir;
        if (pop) begin
            if (verbose)
                $display("[TB] cycle %0d decode accepts pc=%h inst=%h", cyc, m_fifo[0].pc, m_fifo[0].data);
            void'(m_fifo.pop_front());
        end
        if (rsp) begin
            f = m_infl.pop_front();
            void'(pend.pop_front());
            if (!f.drop && !redir) begin
                e.data = mem_word(f.pc); e.pc = f.pc;
                m_fifo.push_back(e);
            end
        end
        if (fire) begin
            f.pc = m_fetch_pc; f.drop = 1'b0;
            m_infl.push_back(f);
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (pend.size() != 0 && due <= pend[pend.size()-1].due)
                due = pend[pend.size()-1].due + 1;
            p.addr = m_fetch_pc; p.due = due;
            pend.push_back(p);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].drop = 1'b1;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end
        if (m_fifo.size() != 0) begin
            m_head_data = m_fifo[0].data; m_head_pc = m_fifo[0].pc;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        t1[7];
        vec_t        t2[9];
        bit          seen_req, seen_iv;
        logic [31:0] first_pc;

        // 1-cycle memory, decode always ready: credit-limited streaming from RESET_PC
        t1[0] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        t1[1] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        t1[2] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        t1[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        t1[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h4};
        t1[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        t1[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        // decode stalled: two reads then no more; release drains in order and resumes at 8
        t2[0] = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        t2[1] = '{1'b1, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
        t2[2] = '{1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        t2[3] = '{1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        t2[4] = '{1'b1, 1'b0, 1'b0, 32'h8,  1'b1, 32'h0};
        t2[5] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        t2[6] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        t2[7] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h4};
        t2[8] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};

        #2;
        lat_lo = 1; lat_hi = 1;
        do_reset();
        foreach (t1[i]) begin
            tick(t1[i].rr, t1[i].ir, 1'b0, 32'h0);
            chk("t1_req_valid", obs_rv, t1[i].rv);
            chk("t1_req_addr", obs_addr, t1[i].addr);
            chk("t1_inst_valid", obs_iv, t1[i].iv);
            chk("t1_inst_pc", obs_pc, t1[i].pc);
            if (t1[i].iv) chk("t1_inst_data", obs_out, mem_word(t1[i].pc));
        end

        do_reset();
        foreach (t2[i]) begin
            tick(t2[i].rr, t2[i].ir, 1'b0, 32'h0);
            chk("t2_req_valid", obs_rv, t2[i].rv);
            chk("t2_req_addr", obs_addr, t2[i].addr);
            chk("t2_inst_valid", obs_iv, t2[i].iv);
            chk("t2_inst_pc", obs_pc, t2[i].pc);
        end

        // redirect to an unaligned target with two reads in flight
        lat_lo = 3; lat_hi = 3;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h103);
        chk("t3_flushed", inst_valid, 0);
        seen_req = 1'b0; seen_iv = 1'b0;
        for (int i = 0; i < 20 && !seen_iv; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_rv && !seen_req) begin
                seen_req = 1'b1;
                chk("t3_first_req_addr", obs_addr, 32'h100);
            end
            if (obs_iv) begin
                seen_iv = 1'b1;
                chk("t3_first_inst_pc", obs_pc, 32'h100);
                chk("t3_first_inst_data", obs_out, mem_word(32'h100));
            end
        end
        chk("t3_output_seen", seen_req && seen_iv, 1);

        // redirect in the same cycle as a pop and an arriving response
        lat_lo = 1; lat_hi = 1;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        popped.delete();
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        chk("t4_pop_valid", obs_iv, 1);
        chk("t4_pop_pc", obs_pc, 32'h0);
        chk("t4_flushed", inst_valid, 0);
        seen_iv = 1'b0; first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !seen_iv; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_iv) begin seen_iv = 1'b1; first_pc = obs_pc; end
        end
        chk("t4_first_pc_after", first_pc, 32'h200);
        chk("t4_accept_count", popped.size(), 2);
        if (popped.size() >= 2) chk("t4_second_accept", popped[1], 32'h200);

        // address wrap at the top of the 32-bit space
        do_reset();
        popped.delete();
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5_accept_count", popped.size() >= 4, 1);
        if (popped.size() >= 4) begin
            chk("t5_pc0", popped[0], 32'hFFFF_FFF8);
            chk("t5_pc1", popped[1], 32'hFFFF_FFFC);
            chk("t5_pc2", popped[2], 32'h0000_0000);
            chk("t5_pc3", popped[3], 32'h0000_0004);
        end

        // randomized ready, latency 1..3, occasional redirects and mid-run resets
        verbose = 1'b0;
        lat_lo = 1; lat_hi = 3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom();
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
                     $urandom_range(39, 0) == 0, rpc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
